route_decoder: RTL and testbench

Clocked, parametrised successor of the 1-of-2 quadtree routing decoder for the NoC. It accepts packets on a valid/ready input and reads the packet's destination address field. In non-leaf mode it routes on one address bit chosen by tree level; in leaf mode it routes on a masked compare against the node address. Packets go to one of two buffered output ports, so the decoder sits between tree levels of the router and decouples upstream from downstream stalls.

---
 rtl/route_decoder.sv | 178 +++++++++++++++++
 tb/tb_route_decoder.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/route_decoder.sv
// route_decoder
// Clocked 1-of-2 quadtree routing decoder for the NoC. A packet accepted on
// the valid/ready input is parked in a single holding register, its output
// port is decided from the destination address field, and it is then pushed
// into one of two circular-buffer FIFOs that feed the downstream ports.
//
// Routing:
//   LEAF = 0 : port = A[ADDR_W-1-LEVEL]
//   LEAF = 1 : port = ((A & MASK) == NODE_ADDR) ? 0 : 1, MASK = LEVEL MSB ones
//
// Optional build macro ROUTE_DECODER_STATS_EN adds saturating 16-bit
// per-port dispatch counters on ports cnt0/cnt1. Routing is unaffected.
module route_decoder #(
   parameter int                DATA_W    = 9,
   parameter int                ADDR_W    = 4,
   parameter int                LEVEL     = 0,
   parameter int                LEAF      = 0,
   parameter logic [ADDR_W-1:0] NODE_ADDR = '0,
   parameter int                DEPTH     = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out0_valid,
   input  logic              out0_ready,
   output logic [DATA_W-1:0] out0_data,
   output logic              out1_valid,
   input  logic              out1_ready,
   output logic [DATA_W-1:0] out1_data,
   output logic              sel_valid,
   output logic              sel
`ifdef ROUTE_DECODER_STATS_EN
   ,
   output logic [15:0]       cnt0,
   output logic [15:0]       cnt1
`endif
);

   localparam int                PTR_W      = $clog2(DEPTH);
   localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]    CNT_ONE    = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
   localparam logic [ADDR_W-1:0] LEAF_MASK  = ~({ADDR_W{1'b1}} >> LEVEL);

   logic [ADDR_W-1:0] w_addr;
   logic              w_inPort;
   logic              w_accept;
   logic              w_dispatch;
   logic [1:0]        w_outReady;
   logic [1:0]        w_outValid;
   logic [1:0]        w_pop;
   logic [1:0]        w_push;
   logic [1:0]        w_space;

   logic              r_holdValid;
   logic [DATA_W-1:0] r_holdData;
   logic              r_holdPort;

   logic [DATA_W-1:0] r_mem   [2][DEPTH];
   logic [PTR_W-1:0]  r_wrPtr [2];
   logic [PTR_W-1:0]  r_rdPtr [2];
   logic [PTR_W:0]    r_count [2];

   // Decide the destination port of the packet currently on the input bus.
   // Only the address field matters; the payload bits below it never steer.
   always_comb begin
      w_addr = in_data[DATA_W-1 -: ADDR_W];
      if (LEAF != 0) begin
         w_inPort = ((w_addr & LEAF_MASK) == NODE_ADDR) ? 1'b0 : 1'b1;
      end else begin
         w_inPort = w_addr[ADDR_W-1-LEVEL];
      end
   end

   // FIFO status. A full FIFO still has room when it is being popped in the
   // same cycle, which is what keeps a saturated port at one packet per cycle.
   assign w_outReady    = {out1_ready, out0_ready};
   assign w_outValid[0] = (r_count[0] != '0);
   assign w_outValid[1] = (r_count[1] != '0);
   assign w_pop[0]      = w_outValid[0] && w_outReady[0];
   assign w_pop[1]      = w_outValid[1] && w_outReady[1];
   assign w_space[0]    = (r_count[0] != FULL_COUNT) || w_pop[0];
   assign w_space[1]    = (r_count[1] != FULL_COUNT) || w_pop[1];

   // Dispatch only looks at the held packet's own port, so a blocked packet
   // stalls the input even when the other port has room (head-of-line).
   always_comb begin
      w_dispatch = r_holdValid && w_space[r_holdPort];
      w_push     = 2'b00;
      if (w_dispatch) begin
         w_push[r_holdPort] = 1'b1;
      end
   end

   // The input is ready when the hold register is empty or is emptying now;
   // this never looks at in_valid or in_data.
   assign in_ready = !r_holdValid || w_dispatch;
   assign w_accept = in_valid && in_ready;

   assign sel_valid  = w_dispatch;
   assign sel        = w_dispatch & r_holdPort;
   assign out0_valid = w_outValid[0];
   assign out1_valid = w_outValid[1];
   assign out0_data  = r_mem[0][r_rdPtr[0]];
   assign out1_data  = r_mem[1][r_rdPtr[1]];

   // Holding register: a new accept overwrites it (reload on dispatch),
   // otherwise a dispatch simply empties it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_holdValid <= 1'b0;
         r_holdData  <= '0;
         r_holdPort  <= 1'b0;
      end else if (w_accept) begin
         r_holdValid <= 1'b1;
         r_holdData  <= in_data;
         r_holdPort  <= w_inPort;
      end else if (w_dispatch) begin
         r_holdValid <= 1'b0;
      end
   end

   // Two circular buffers. Pointers wrap naturally because DEPTH is a power
   // of two; simultaneous push and pop leave the occupancy unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < 2; p++) begin
            r_wrPtr[p] <= '0;
            r_rdPtr[p] <= '0;
            r_count[p] <= '0;
            for (int i = 0; i < DEPTH; i++) begin
               r_mem[p][i] <= '0;
            end
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (w_push[p]) begin
               r_mem[p][r_wrPtr[p]] <= r_holdData;
               r_wrPtr[p]           <= r_wrPtr[p] + PTR_ONE;
            end
            if (w_pop[p]) begin
               r_rdPtr[p] <= r_rdPtr[p] + PTR_ONE;
            end
            if (w_push[p] && !w_pop[p]) begin
               r_count[p] <= r_count[p] + CNT_ONE;
            end else if (!w_push[p] && w_pop[p]) begin
               r_count[p] <= r_count[p] - CNT_ONE;
            end
         end
      end
   end

`ifdef ROUTE_DECODER_STATS_EN
   logic [15:0] r_cnt0;
   logic [15:0] r_cnt1;

   // Per-port dispatch counters; they stick at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt0 <= 16'h0000;
         r_cnt1 <= 16'h0000;
      end else begin
         if (w_push[0] && (r_cnt0 != 16'hFFFF)) begin
            r_cnt0 <= r_cnt0 + 16'd1;
         end
         if (w_push[1] && (r_cnt1 != 16'hFFFF)) begin
            r_cnt1 <= r_cnt1 + 16'd1;
         end
      end
   end

   assign cnt0 = r_cnt0;
   assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_route_decoder.sv
// tb_route_decoder
// Bench for route_decoder. Two instances: a bit-route node (LEAF=0, LEVEL=2)
// carrying most scenarios, and a leaf node (LEAF=1, LEVEL=2, NODE_ADDR=0100)
// for the masked-compare rule. Expected ports come from a small arithmetic
// model of the routing rules; packet order is tracked with queues.
// The counter scenario is built only with ROUTE_DECODER_STATS_EN.
module tb_route_decoder;

   localparam int DATA_W = 9;
   localparam int ADDR_W = 4;
   localparam int LEVEL  = 2;
   localparam int DEPTH  = 2;
   localparam int NODE   = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic              inValid, inReady;
   logic [DATA_W-1:0] inData;
   logic              out0Valid, out0Ready, out1Valid, out1Ready;
   logic [DATA_W-1:0] out0Data, out1Data;
   logic              selValid, sel;

   logic              lfInValid, lfInReady;
   logic [DATA_W-1:0] lfInData;
   logic              lfOut0Valid, lfOut0Ready, lfOut1Valid, lfOut1Ready;
   logic [DATA_W-1:0] lfOut0Data, lfOut1Data;
   logic              lfSelValid, lfSel;

`ifdef ROUTE_DECODER_STATS_EN
   logic [15:0] cnt0, cnt1, lfCnt0, lfCnt1;
`endif

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   route_decoder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEVEL(LEVEL), .LEAF(0),
                   .NODE_ADDR(4'b0000), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .in_valid(inValid), .in_ready(inReady), .in_data(inData),
      .out0_valid(out0Valid), .out0_ready(out0Ready), .out0_data(out0Data),
      .out1_valid(out1Valid), .out1_ready(out1Ready), .out1_data(out1Data),
      .sel_valid(selValid), .sel(sel)
`ifdef ROUTE_DECODER_STATS_EN
      , .cnt0(cnt0), .cnt1(cnt1)
`endif
   );

   route_decoder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEVEL(LEVEL), .LEAF(1),
                   .NODE_ADDR(4'b0100), .DEPTH(DEPTH)) dutLeaf (
      .clk(clk), .reset(reset),
      .in_valid(lfInValid), .in_ready(lfInReady), .in_data(lfInData),
      .out0_valid(lfOut0Valid), .out0_ready(lfOut0Ready), .out0_data(lfOut0Data),
      .out1_valid(lfOut1Valid), .out1_ready(lfOut1Ready), .out1_data(lfOut1Data),
      .sel_valid(lfSelValid), .sel(lfSel)
`ifdef ROUTE_DECODER_STATS_EN
      , .cnt0(lfCnt0), .cnt1(lfCnt1)
`endif
   );

   // Reference routing: bit-route picks one address bit by arithmetic shift;
   // leaf mode truncates the low (ADDR_W-level) bits and compares to the node.
   function automatic int modelPort(input logic [DATA_W-1:0] d, input int leaf,
                                    input int level, input int node);
      int a;
      int keep;
      a = int'(d[DATA_W-1:DATA_W-ADDR_W]);
      if (leaf == 0) return (a >> (ADDR_W-1-level)) & 1;
      keep = ADDR_W - level;
      return (((a >> keep) << keep) == node) ? 0 : 1;
   endfunction

   // Random packet whose bit-route destination is the requested port.
   function automatic logic [DATA_W-1:0] mkPkt(input int port);
      logic [DATA_W-1:0] d;
      d = DATA_W'($urandom);
      d[DATA_W-ADDR_W+(ADDR_W-1-LEVEL)] = port[0];
      return d;
   endfunction

   task automatic nextCycle;
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs;
      inValid = 0; inData = '0; out0Ready = 0; out1Ready = 0;
      lfInValid = 0; lfInData = '0; lfOut0Ready = 0; lfOut1Ready = 0;
   endtask

   task automatic applyReset;
      idleInputs();
      reset = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 0;
   endtask

   // Reset values on both instances.
   task automatic test_reset;
      idleInputs();
      reset = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (inReady !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", inReady); else passes++;
      checks++; if (out0Valid !== 1'b0) $display("[TB] FAIL reset_out0_valid: got %b want 0", out0Valid); else passes++;
      checks++; if (out1Valid !== 1'b0) $display("[TB] FAIL reset_out1_valid: got %b want 0", out1Valid); else passes++;
      checks++; if (selValid !== 1'b0 || sel !== 1'b0) $display("[TB] FAIL reset_sel: got %b/%b want 0/0", selValid, sel); else passes++;
      checks++; if (out0Data !== '0 || out1Data !== '0) $display("[TB] FAIL reset_data: got %h/%h want 0/0", out0Data, out1Data); else passes++;
      checks++; if (lfInReady !== 1'b1 || lfOut0Valid !== 1'b0 || lfOut1Valid !== 1'b0)
         $display("[TB] FAIL reset_leaf: got rdy=%b v0=%b v1=%b want 1/0/0", lfInReady, lfOut0Valid, lfOut1Valid); else passes++;
`ifdef ROUTE_DECODER_STATS_EN
      checks++; if (cnt0 !== 16'h0 || cnt1 !== 16'h0) $display("[TB] FAIL reset_cnt: got %h/%h want 0/0", cnt0, cnt1); else passes++;
`endif
      reset = 0;
      nextCycle();
      @(negedge clk);
      checks++; if (inReady !== 1'b1 || out0Valid !== 1'b0 || out1Valid !== 1'b0)
         $display("[TB] FAIL post_reset_idle: got rdy=%b v0=%b v1=%b want 1/0/0", inReady, out0Valid, out1Valid); else passes++;
   endtask

   // Bit-route: single packets, sel at t+1, output at t+2.
   task automatic test_bit_route;
      logic [DATA_W-1:0] pkts [2];
      int expPort;
      logic gotValid, otherValid;
      logic [DATA_W-1:0] gotData;
      pkts[0] = 9'h0A0;
      pkts[1] = 9'h0C0;
      for (int k = 0; k < 2; k++) begin
         expPort = modelPort(pkts[k], 0, LEVEL, 0);
         nextCycle();
         inValid = 1; inData = pkts[k];
         @(negedge clk);
         checks++; if (inReady !== 1'b1) $display("[TB] FAIL bit_accept[%0d]: got %b want 1", k, inReady); else passes++;
         nextCycle();
         inValid = 0;
         @(negedge clk);
         checks++; if (selValid !== 1'b1 || sel !== expPort[0])
            $display("[TB] FAIL bit_sel[%0d]: got %b/%b want 1/%0d", k, selValid, sel, expPort); else passes++;
         nextCycle();
         @(negedge clk);
         gotValid   = expPort[0] ? out1Valid : out0Valid;
         otherValid = expPort[0] ? out0Valid : out1Valid;
         gotData    = expPort[0] ? out1Data : out0Data;
         checks++; if (gotValid !== 1'b1 || otherValid !== 1'b0 || gotData !== pkts[k])
            $display("[TB] FAIL bit_out[%0d]: got v=%b other=%b d=%h want 1/0/%h", k, gotValid, otherValid, gotData, pkts[k]); else passes++;
         nextCycle();
         out0Ready = 1; out1Ready = 1;
         nextCycle();
         out0Ready = 0; out1Ready = 0;
         @(negedge clk);
         checks++; if (out0Valid !== 1'b0 || out1Valid !== 1'b0)
            $display("[TB] FAIL bit_drain[%0d]: got %b/%b want 0/0", k, out0Valid, out1Valid); else passes++;
      end
   endtask

   // Leaf masked compare on the second instance.
   task automatic test_leaf_route;
      logic [ADDR_W-1:0] addrs [3];
      int expPort;
      logic gotValid, otherValid;
      logic [DATA_W-1:0] gotData, sent;
      addrs[0] = 4'b0101;
      addrs[1] = 4'b1001;
      addrs[2] = 4'b0111;
      for (int k = 0; k < 3; k++) begin
         nextCycle();
         sent = {addrs[k], 5'($urandom)};
         expPort = modelPort(sent, 1, LEVEL, NODE);
         lfInValid = 1; lfInData = sent;
         @(negedge clk);
         checks++; if (lfInReady !== 1'b1) $display("[TB] FAIL leaf_accept[%0d]: got %b want 1", k, lfInReady); else passes++;
         nextCycle();
         lfInValid = 0;
         @(negedge clk);
         checks++; if (lfSelValid !== 1'b1 || lfSel !== expPort[0])
            $display("[TB] FAIL leaf_sel[%0d]: got %b/%b want 1/%0d", k, lfSelValid, lfSel, expPort); else passes++;
         nextCycle();
         @(negedge clk);
         gotValid   = expPort[0] ? lfOut1Valid : lfOut0Valid;
         otherValid = expPort[0] ? lfOut0Valid : lfOut1Valid;
         gotData    = expPort[0] ? lfOut1Data : lfOut0Data;
         checks++; if (gotValid !== 1'b1 || otherValid !== 1'b0 || gotData !== sent)
            $display("[TB] FAIL leaf_out[%0d]: got v=%b other=%b d=%h want 1/0/%h", k, gotValid, otherValid, gotData, sent); else passes++;
         nextCycle();
         lfOut0Ready = 1; lfOut1Ready = 1;
         nextCycle();
         lfOut0Ready = 0; lfOut1Ready = 0;
      end
   endtask

   // Port 0 stalled: 2 in FIFO, 1 held, then a port-1 packet must wait.
   task automatic test_head_of_line;
      logic [DATA_W-1:0] pkts [4];
      int sent, idx0, got1, guard;
      for (int k = 0; k < 3; k++) pkts[k] = mkPkt(0);
      pkts[3] = mkPkt(1);
      out0Ready = 0; out1Ready = 0;
      sent = 0; guard = 0;
      while (sent < 3 && guard < 20) begin
         nextCycle();
         inValid = 1; inData = pkts[sent];
         @(negedge clk);
         if (inReady) sent++;
         guard++;
      end
      checks++; if (sent !== 3) $display("[TB] FAIL hol_fill: got %0d accepted want 3", sent); else passes++;
      for (int c = 0; c < 4; c++) begin
         nextCycle();
         inValid = 1; inData = pkts[3];
         @(negedge clk);
         checks++; if (inReady !== 1'b0 || out1Valid !== 1'b0 || out0Valid !== 1'b1 || out0Data !== pkts[0])
            $display("[TB] FAIL hol_blocked[%0d]: got rdy=%b v1=%b v0=%b d0=%h want 0/0/1/%h",
                     c, inReady, out1Valid, out0Valid, out0Data, pkts[0]); else passes++;
      end
      idx0 = 0; got1 = 0;
      for (int c = 0; c < 20; c++) begin
         nextCycle();
         out0Ready = 1; out1Ready = 1;
         @(negedge clk);
         if (out0Valid && out0Ready) begin
            checks++; if (idx0 > 2 || out0Data !== pkts[idx0 > 2 ? 2 : idx0])
               $display("[TB] FAIL hol_order0[%0d]: got %h want %h", idx0, out0Data, pkts[idx0 > 2 ? 2 : idx0]); else passes++;
            idx0++;
         end
         if (out1Valid && out1Ready) begin
            checks++; if (out1Data !== pkts[3]) $display("[TB] FAIL hol_out1: got %h want %h", out1Data, pkts[3]); else passes++;
            got1++;
         end
         if (inValid && inReady) begin
            nextCycle();
            inValid = 0;
            @(negedge clk);
            if (out0Valid && out0Ready) begin
               checks++; if (idx0 > 2 || out0Data !== pkts[idx0 > 2 ? 2 : idx0])
                  $display("[TB] FAIL hol_order0[%0d]: got %h want %h", idx0, out0Data, pkts[idx0 > 2 ? 2 : idx0]); else passes++;
               idx0++;
            end
         end
      end
      checks++; if (idx0 !== 3 || got1 !== 1) $display("[TB] FAIL hol_drain: got %0d/%0d want 3/1", idx0, got1); else passes++;
      out0Ready = 0; out1Ready = 0;
   endtask

   // Full FIFO + held packet, then 100 back-to-back packets at 1/cycle.
   task automatic test_back_to_back;
      logic [DATA_W-1:0] q [$];
      logic [DATA_W-1:0] exp;
      int sent, guard, accepted, pops, stalls;
      out0Ready = 0; out1Ready = 0;
      sent = 0; guard = 0;
      while (sent < 3 && guard < 20) begin
         nextCycle();
         inValid = 1; inData = mkPkt(0);
         @(negedge clk);
         if (inReady) begin sent++; q.push_back(inData); end
         guard++;
      end
      accepted = 0; pops = 0; stalls = 0;
      for (int c = 0; c < 100; c++) begin
         nextCycle();
         out0Ready = 1; inValid = 1; inData = mkPkt(0);
         @(negedge clk);
         if (out0Valid && out0Ready) begin
            exp = (q.size() > 0) ? q.pop_front() : 'x;
            checks++; if (out0Data !== exp) $display("[TB] FAIL b2b_order: got %h want %h", out0Data, exp); else passes++;
            pops++;
         end
         if (!selValid) stalls++;
         if (inReady) begin accepted++; q.push_back(inData); end
      end
      checks++; if (accepted !== 100) $display("[TB] FAIL b2b_accept_rate: got %0d want 100", accepted); else passes++;
      checks++; if (pops !== 100) $display("[TB] FAIL b2b_pop_rate: got %0d want 100", pops); else passes++;
      checks++; if (stalls !== 0) $display("[TB] FAIL b2b_dispatch_bubbles: got %0d want 0", stalls); else passes++;
      for (int c = 0; c < 10; c++) begin
         nextCycle();
         inValid = 0;
         @(negedge clk);
         if (out0Valid && out0Ready) begin
            exp = (q.size() > 0) ? q.pop_front() : 'x;
            checks++; if (out0Data !== exp) $display("[TB] FAIL b2b_drain_order: got %h want %h", out0Data, exp); else passes++;
         end
      end
      checks++; if (q.size() !== 0) $display("[TB] FAIL b2b_drain_left: got %0d want 0", q.size()); else passes++;
      out0Ready = 0;
   endtask

   // Random traffic against the order/port scoreboard.
   task automatic test_random;
      logic [DATA_W-1:0] q0 [$];
      logic [DATA_W-1:0] q1 [$];
      int acc [$];
      logic [DATA_W-1:0] exp, prev0, prev1;
      logic hold0, hold1;
      int expSel;
      applyReset();
      hold0 = 0; hold1 = 0; prev0 = '0; prev1 = '0;
      for (int c = 0; c < 3030; c++) begin
         nextCycle();
         if (c < 3000) begin
            inValid   = ($urandom_range(0, 9) < 7);
            inData    = DATA_W'($urandom);
            out0Ready = ($urandom_range(0, 9) < 6);
            out1Ready = ($urandom_range(0, 9) < 6);
         end else begin
            inValid = 0; out0Ready = 1; out1Ready = 1;
         end
         @(negedge clk);
         if (hold0) begin
            checks++; if (out0Valid !== 1'b1 || out0Data !== prev0)
               $display("[TB] FAIL rnd_stable0: got %b/%h want 1/%h", out0Valid, out0Data, prev0); else passes++;
         end
         if (hold1) begin
            checks++; if (out1Valid !== 1'b1 || out1Data !== prev1)
               $display("[TB] FAIL rnd_stable1: got %b/%h want 1/%h", out1Valid, out1Data, prev1); else passes++;
         end
         if (selValid) begin
            expSel = (acc.size() > 0) ? acc.pop_front() : -1;
            checks++; if (expSel < 0 || sel !== expSel[0]) $display("[TB] FAIL rnd_sel: got %b want %0d", sel, expSel); else passes++;
         end
         if (out0Valid && out0Ready) begin
            exp = (q0.size() > 0) ? q0.pop_front() : 'x;
            checks++; if (out0Data !== exp) $display("[TB] FAIL rnd_out0: got %h want %h", out0Data, exp); else passes++;
         end
         if (out1Valid && out1Ready) begin
            exp = (q1.size() > 0) ? q1.pop_front() : 'x;
            checks++; if (out1Data !== exp) $display("[TB] FAIL rnd_out1: got %h want %h", out1Data, exp); else passes++;
         end
         if (inValid && inReady) begin
            expSel = modelPort(inData, 0, LEVEL, 0);
            acc.push_back(expSel);
            if (expSel == 0) q0.push_back(inData); else q1.push_back(inData);
         end
         hold0 = out0Valid && !out0Ready; prev0 = out0Data;
         hold1 = out1Valid && !out1Ready; prev1 = out1Data;
      end
      checks++; if (q0.size() !== 0 || q1.size() !== 0 || acc.size() !== 0)
         $display("[TB] FAIL rnd_leftover: got %0d/%0d/%0d want 0/0/0", q0.size(), q1.size(), acc.size()); else passes++;
      out0Ready = 0; out1Ready = 0;
   endtask

   // Asynchronous reset with packets buffered on both ports.
   task automatic test_reset_mid_stream;
      int sent, guard;
      out0Ready = 0; out1Ready = 0;
      sent = 0; guard = 0;
      while (sent < 4 && guard < 20) begin
         nextCycle();
         inValid = 1; inData = mkPkt(sent % 2);
         @(negedge clk);
         if (inReady) sent++;
         guard++;
      end
      nextCycle();
      inValid = 0;
      nextCycle();
      @(negedge clk);
      checks++; if (out0Valid !== 1'b1 || out1Valid !== 1'b1)
         $display("[TB] FAIL mid_preload: got %b/%b want 1/1", out0Valid, out1Valid); else passes++;
      @(posedge clk);
      #2;
      reset = 1;
      #1;
      checks++; if (out0Valid !== 1'b0 || out1Valid !== 1'b0 || inReady !== 1'b1)
         $display("[TB] FAIL mid_async: got v0=%b v1=%b rdy=%b want 0/0/1", out0Valid, out1Valid, inReady); else passes++;
      @(negedge clk);
      reset = 0;
      nextCycle();
      @(negedge clk);
      checks++; if (out0Valid !== 1'b0 || out1Valid !== 1'b0 || inReady !== 1'b1 || selValid !== 1'b0)
         $display("[TB] FAIL mid_after: got v0=%b v1=%b rdy=%b sv=%b want 0/0/1/0", out0Valid, out1Valid, inReady, selValid); else passes++;
`ifdef ROUTE_DECODER_STATS_EN
      checks++; if (cnt0 !== 16'h0 || cnt1 !== 16'h0) $display("[TB] FAIL mid_cnt: got %h/%h want 0/0", cnt0, cnt1); else passes++;
`endif
   endtask

`ifdef ROUTE_DECODER_STATS_EN
   // Counter saturation: 3 dispatches to port 0, 70000 to port 1.
   task automatic test_stats;
      int sent;
      applyReset();
      out0Ready = 1; out1Ready = 1;
      sent = 0;
      for (int c = 0; c < 71000 && sent < 70003; c++) begin
         nextCycle();
         inValid = 1; inData = mkPkt(sent < 3 ? 0 : 1);
         @(negedge clk);
         if (inReady) sent++;
      end
      nextCycle();
      inValid = 0;
      repeat (3) nextCycle();
      @(negedge clk);
      checks++; if (sent !== 70003) $display("[TB] FAIL stats_sent: got %0d want 70003", sent); else passes++;
      checks++; if (cnt0 !== 16'd3) $display("[TB] FAIL stats_cnt0: got %h want 0003", cnt0); else passes++;
      checks++; if (cnt1 !== 16'hFFFF) $display("[TB] FAIL stats_cnt1: got %h want ffff", cnt1); else passes++;
   endtask
`endif

   initial begin
      idleInputs();
      test_reset();
      test_bit_route();
      test_leaf_route();
      test_head_of_line();
      test_back_to_back();
      test_random();
      test_reset_mid_stream();
`ifdef ROUTE_DECODER_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
